// File: rtl/pmu_cfg_arbiter_if.sv
// Configuration-write bus between the PMU config masters and the arbiter:
// packed per-requester beats in, one registered register-file write port out.
interface pmu_cfg_arbiter_if #(
    parameter int N_REQ     = 2,
    parameter int REG_WIDTH = 32,
    parameter int ADDR_W    = 6
);
    logic [N_REQ-1:0]           req_valid_i;
    logic [N_REQ-1:0]           req_ready_o;
    logic [N_REQ*ADDR_W-1:0]    req_addr_i;
    logic [N_REQ*REG_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]           req_lock_i;
    logic                       wr_en_o;
    logic [ADDR_W-1:0]          wr_addr_o;
    logic [REG_WIDTH-1:0]       wr_data_o;
    logic [N_REQ-1:0]           grant_o;
    logic                       err_addr_o;
    logic                       lock_to_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_lock_i,
        input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o, grant_o, err_addr_o, lock_to_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_lock_i,
        output req_ready_o, wr_en_o, wr_addr_o, wr_data_o, grant_o, err_addr_o, lock_to_o
    );
endinterface

// File: rtl/pmu_cfg_arbiter.sv
// Round-robin arbiter sharing the PMU configuration register file between
// several masters, with locked multi-beat sequences and an idle-lock timeout.
module pmu_cfg_arbiter #(
    parameter int N_REQ        = 2,
    parameter int REG_WIDTH    = 32,
    parameter int N_REGS       = 47,
    parameter int ADDR_W       = 6,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    pmu_cfg_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic                 err_q, err_d;
    logic                 lto_q, lto_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [PTR_W-1:0]     sel;
    logic                 sel_vld;
    logic [ADDR_W-1:0]    sel_addr;
    logic [REG_WIDTH-1:0] sel_data;
    logic                 sel_lock;
    logic                 addr_ok;
    logic                 accept;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        if (int'(idx) >= N_REQ - 1) return '0;
        return idx + PTR_W'(1);
    endfunction

    // Winner selection: the owner while locked, otherwise the first valid
    // requester at or after the pointer. Descending scan leaves the highest
    // priority candidate as the final assignment.
    always_comb begin
        int idx;
        sel     = owner_q;
        sel_vld = 1'b0;
        idx     = 0;
        if (state_q == LOCKED) begin
            sel_vld = bus.req_valid_i[owner_q];
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                idx = (int'(ptr_q) + i) % N_REQ;
                if (bus.req_valid_i[idx]) begin
                    sel     = PTR_W'(idx);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (sel_vld) bus.req_ready_o[sel] = 1'b1;
    end

    assign accept   = sel_vld;
    assign sel_addr = bus.req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data_i[int'(sel)*REG_WIDTH +: REG_WIDTH];
    assign sel_lock = bus.req_lock_i[sel];
    assign addr_ok  = int'(sel_addr) < N_REGS;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        wr_en_d   = accept & addr_ok;
        err_d     = accept & ~addr_ok;
        lto_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Illegal beats still move the lock/pointer but leave the write port untouched.
        if (accept && addr_ok) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_lock) begin
                        state_d = LOCKED;
                        owner_d = sel;
                        cnt_d   = '0;
                    end else begin
                        ptr_d = next_idx(sel);
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (sel_lock) begin
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end else if (int'(cnt_q) >= LOCK_TIMEOUT - 1) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                    lto_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            lto_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            lto_q     <= lto_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        bus.grant_o = '0;
        if (state_q == LOCKED) bus.grant_o[owner_q] = 1'b1;
    end

    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.err_addr_o = err_q;
    assign bus.lock_to_o  = lto_q;
endmodule
